line_buf_ctrl_5x5: RTL and testbench
====================================

// Module: line_buf_ctrl_5x5
// PURPOSE
//   Controller that sits between the pixel input stream and six 512-deep line buffers
//   (8-bit write, combinational 40-bit 5-pixel read at the read pointer).
//   Writes incoming pixels into the buffers in round-robin order.
//   Once five full lines are stored, reads the five oldest buffers in lockstep and
//   presents a 5x5 window (200 bits) to the convolution stage.
//   Tracks buffer fill to give the upstream source back-pressure.
// PARAMETERS
//   LINE_W  512  pixels per image line; must equal line-buffer depth; power of 2
//   PIX_W   8    bits per pixel; window row = 5*PIX_W bits
// PORTS
//   i_clk         in   1        clock
//   i_rst         in   1        sync active-high reset
//   i_pix_data    in   PIX_W    input pixel
//   i_pix_valid   in   1        pixel present; accepted only when o_pix_ready=1
//   o_pix_ready   out  1        1 when fill < 6*LINE_W
//   o_lb_wr_data  out  PIX_W    = i_pix_data, broadcast to all six buffers
//   o_lb_wr_vld   out  6        one-hot write strobe: bit wr_buf when pixel accepted, else 0
//   o_lb_rd       out  6        read-advance strobes to the six buffers
//   i_lb_data     in   6*5*PIX_W  buffer k output at [k*40 +: 40]
//   o_win_data    out  25*PIX_W  [199:160] = oldest row ... [39:0] = newest row
//   o_win_valid   out  1        window valid this cycle
//   i_win_ready   in   1        consumer accepts the window
//   o_line_irq    out  1        1-cycle pulse per completed output line (see CONFIGURATION)
// BEHAVIOUR
//   Reset
//     wr_buf, rd_buf, wr_col, rd_col and fill all = 0; state = IDLE.
//     Outputs after reset: o_pix_ready = 1; o_lb_wr_vld, o_lb_rd, o_win_valid, o_line_irq = 0.
//     Reset mid-line discards all stored data; no partial window is emitted.
//   Write path
//     Accept = i_pix_valid & o_pix_ready.
//     On accept: wr_col++. When wr_col wraps from LINE_W-1 to 0, wr_buf = (wr_buf+1) mod 6.
//     When not ready, i_pix_valid is ignored: no write, no counter change.
//   Fill counter
//     Width clog2(6*LINE_W+1).
//     Increments by 1 per accepted pixel.
//     Decrements by LINE_W on line release.
//     Both in the same cycle: net change = +1-LINE_W.
//     Never exceeds 6*LINE_W.
//   Read FSM: IDLE, READ
//     IDLE -> READ when fill >= 5*LINE_W; rd_col = 0.
//     In READ:
//       adv = (rd_col >= LINE_W-4) | i_win_ready.
//       o_lb_rd[k] = adv for the five buffers rd_buf..rd_buf+4 (mod 6); 0 for the sixth.
//       o_win_valid = (rd_col < LINE_W-4); edge columns advance silently.
//       On adv: rd_col++.
//     On adv with rd_col = LINE_W-1: line release.
//       rd_buf = (rd_buf+1) mod 6; fill -= LINE_W; o_line_irq pulses next cycle.
//       Next state = READ if (fill after update) >= 5*LINE_W, else IDLE.
//   Window data
//     o_win_data is a combinational mux of i_lb_data.
//     Row r (r = 0 oldest) comes from buffer (rd_buf+r) mod 6.
//     Row r is placed at [(4-r)*40 +: 40].
//     Zero latency from read pointer to window.
//   Window handshake
//     o_win_data holds stable while o_win_valid=1 and i_win_ready=0.
//     LINE_W-4 windows are emitted per output line.
//   Buffer overlap
//     The write buffer is never among the five read buffers: reads start only at fill >= 5 lines,
//     and the sixth buffer is the one being written.
// CONFIGURATION
//   LBC_IRQ_EN defined: o_line_irq is a registered 1-cycle pulse, cycle after each line release.
//   LBC_IRQ_EN undefined: o_line_irq tied to 0; no irq logic synthesised.
// TESTING
//   1. Reset, then 5*512 pixels with valid always high.
//      -> o_win_valid rises within 2 cycles of the last pixel.
//      -> 508 windows; row0 = line0 pixels[0..4] on the first window.
//   2. Ramp pixel value = col, i_win_ready=1 continuously.
//      -> window n, each row = {n, n+1, n+2, n+3, n+4}.
//      -> o_lb_rd asserted 512 cycles, then rd_buf = 1.
//   3. Stream 6*512 pixels with no read (i_win_ready=0 from start).
//      -> o_pix_ready = 0 after pixel 3072.
//      -> further i_pix_valid produces no o_lb_wr_vld.
//      -> one line release later, o_pix_ready = 1.
//   4. i_win_ready toggled 1/0 every cycle.
//      -> o_win_data stable while stalled; still 508 windows; no duplicates or drops.
//   5. 12 lines streamed. -> wr_buf and rd_buf wrap 5->0.
//      -> 8 output lines total; with LBC_IRQ_EN, exactly 8 o_line_irq pulses.
//   6. Assert i_rst mid-READ at rd_col=100.
//      -> next cycle o_win_valid=0, fill=0, o_pix_ready=1.
//      -> state IDLE until 5 new lines are written.

Source files
------------

// File: rtl/line_buf_ctrl_5x5.sv
// Line-buffer controller: round-robin pixel writes into six line buffers, 5x5 window reads.
// Optional LBC_IRQ_EN: registered one-cycle o_line_irq pulse after each line release.
module line_buf_ctrl_5x5 #(
    parameter int unsigned LINE_W = 512,
    parameter int unsigned PIX_W  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [PIX_W-1:0]       i_pix_data,
    input  logic                   i_pix_valid,
    output logic                   o_pix_ready,
    output logic [PIX_W-1:0]       o_lb_wr_data,
    output logic [5:0]             o_lb_wr_vld,
    output logic [5:0]             o_lb_rd,
    input  logic [6*5*PIX_W-1:0]   i_lb_data,
    output logic [25*PIX_W-1:0]    o_win_data,
    output logic                   o_win_valid,
    input  logic                   i_win_ready,
    output logic                   o_line_irq
);
    localparam int unsigned ROW_W  = 5 * PIX_W;
    localparam int unsigned COL_W  = $clog2(LINE_W);
    localparam int unsigned FILL_W = $clog2(6 * LINE_W + 1);

    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(6 * LINE_W);
    localparam logic [FILL_W-1:0] FILL_RD   = FILL_W'(5 * LINE_W);
    localparam logic [FILL_W-1:0] FILL_LINE = FILL_W'(LINE_W);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_W - 1);
    localparam logic [COL_W-1:0]  COL_EDGE  = COL_W'(LINE_W - 4);

    typedef enum logic {IDLE, READ} state_t;

    state_t             state_q, state_d;
    logic [2:0]         wr_buf_q, rd_buf_q;
    logic [COL_W-1:0]   wr_col_q, rd_col_q;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               accept, adv, release_line;
    logic [2:0]         skip_buf;
    logic [5:0]         rd_mask;

    function automatic logic [2:0] inc6(input logic [2:0] b);
        return (b == 3'd5) ? 3'd0 : b + 3'd1;
    endfunction

    assign accept       = i_pix_valid & o_pix_ready;
    assign o_lb_wr_data = i_pix_data;
    assign o_lb_wr_vld  = accept ? 6'(6'd1 << wr_buf_q) : 6'd0;

    // The buffer just behind rd_buf (mod 6) is the one being written; it is never read.
    assign skip_buf = (rd_buf_q == 3'd0) ? 3'd5 : rd_buf_q - 3'd1;
    assign rd_mask  = ~6'(6'd1 << skip_buf);

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        adv          = 1'b0;
        release_line = 1'b0;
        o_win_valid  = 1'b0;
        o_lb_rd      = 6'd0;
        case (state_q)
            IDLE: begin
                if (fill_q >= FILL_RD) state_d = READ;
            end
            READ: begin
                adv          = (rd_col_q >= COL_EDGE) | i_win_ready;
                o_win_valid  = (rd_col_q < COL_EDGE);
                o_lb_rd      = adv ? rd_mask : 6'd0;
                release_line = adv && (rd_col_q == COL_LAST);
            end
            default: state_d = IDLE;
        endcase
        fill_d = fill_q + FILL_W'(accept) - (release_line ? FILL_LINE : '0);
        if (release_line && (fill_d < FILL_RD)) state_d = IDLE;
    end

    // Pointers, fill level and registered back-pressure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_buf_q    <= 3'd0;
            wr_col_q    <= '0;
            rd_buf_q    <= 3'd0;
            rd_col_q    <= '0;
            fill_q      <= '0;
            o_pix_ready <= 1'b1;
        end else begin
            fill_q      <= fill_d;
            o_pix_ready <= (fill_d < FILL_MAX);
            if (accept) begin
                wr_col_q <= wr_col_q + COL_W'(1);
                if (wr_col_q == COL_LAST) wr_buf_q <= inc6(wr_buf_q);
            end
            if (adv) begin
                rd_col_q <= rd_col_q + COL_W'(1);
                if (release_line) rd_buf_q <= inc6(rd_buf_q);
            end else if (state_q == IDLE) begin
                rd_col_q <= '0;
            end
        end
    end

    // Row r (0 = oldest) comes from buffer (rd_buf + r) mod 6, oldest row in the MSBs.
    always_comb begin
        int unsigned sel;
        sel        = 0;
        o_win_data = '0;
        for (int r = 0; r < 5; r++) begin
            sel = 32'(rd_buf_q) + 32'(r);
            if (sel >= 6) sel = sel - 6;
            o_win_data[(4-r)*ROW_W +: ROW_W] = i_lb_data[sel*ROW_W +: ROW_W];
        end
    end

`ifdef LBC_IRQ_EN
    logic irq_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) irq_q <= 1'b0;
        else       irq_q <= release_line;
    end
    assign o_line_irq = irq_q;
`else
    assign o_line_irq = 1'b0;
`endif

endmodule

// File: tb/tb_line_buf_ctrl_5x5.sv
// Bench for line_buf_ctrl_5x5 with a behavioural model of the six line buffers.
module tb_line_buf_ctrl_5x5;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ROW_W  = 5 * PIX_W;
    localparam int unsigned WIN_W  = 25 * PIX_W;
    localparam int unsigned NWIN   = LINE_W - 4;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic [PIX_W-1:0]   i_pix_data = '0;
    logic               i_pix_valid = 1'b0;
    logic               o_pix_ready;
    logic [PIX_W-1:0]   o_lb_wr_data;
    logic [5:0]         o_lb_wr_vld;
    logic [5:0]         o_lb_rd;
    logic [6*ROW_W-1:0] lb_data;
    logic [WIN_W-1:0]   o_win_data;
    logic               o_win_valid;
    logic               i_win_ready = 1'b0;
    logic               o_line_irq;

    line_buf_ctrl_5x5 #(.LINE_W(LINE_W), .PIX_W(PIX_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_pix_data(i_pix_data), .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready),
        .o_lb_wr_data(o_lb_wr_data), .o_lb_wr_vld(o_lb_wr_vld), .o_lb_rd(o_lb_rd),
        .i_lb_data(lb_data), .o_win_data(o_win_data), .o_win_valid(o_win_valid),
        .i_win_ready(i_win_ready), .o_line_irq(o_line_irq)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0, n_bad = 0;
    int lmul = 0, rmode = 0;
    int cur_line = 0, cur_col = 0;
    int win_cnt = 0, rd_cyc = 0, rd_total = 0, rd_model = 0, irq_cnt = 0, valid_cyc = 0;
    logic prev_stall = 1'b0;
    logic [WIN_W-1:0] prev_data = '0;
    logic [WIN_W-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] pix(input int l, input int c);
        return PIX_W'(c + lmul * l);
    endfunction

    function automatic logic [5:0] mask5(input int b);
        logic [5:0] m;
        m = '0;
        for (int r = 0; r < 5; r++) m[(b + r) % 6] = 1'b1;
        return m;
    endfunction

    // Line buffer model: per-buffer write and read pointers, 5-pixel combinational read.
    logic [PIX_W-1:0] mem [6][LINE_W];
    logic [8:0] wp [6];
    logic [8:0] rp [6];
    always @(posedge i_clk) begin
        for (int k = 0; k < 6; k++) begin
            if (i_rst) begin
                wp[k] <= '0;
                rp[k] <= '0;
            end else begin
                if (o_lb_wr_vld[k]) begin
                    mem[k][wp[k]] <= o_lb_wr_data;
                    wp[k] <= wp[k] + 9'd1;
                end
                if (o_lb_rd[k]) rp[k] <= rp[k] + 9'd1;
            end
        end
    end
    always_comb begin
        lb_data = '0;
        for (int k = 0; k < 6; k++)
            for (int p = 0; p < 5; p++)
                lb_data[k*ROW_W + (4-p)*PIX_W +: PIX_W] = mem[k][9'(rp[k] + 9'(p))];
    end

    task automatic push_line(input int j);
        logic [WIN_W-1:0] w;
        for (int n = 0; n < int'(NWIN); n++) begin
            w = '0;
            for (int r = 0; r < 5; r++)
                for (int p = 0; p < 5; p++)
                    w[(4-r)*ROW_W + (4-p)*PIX_W +: PIX_W] = pix(j + r, n + p);
            exp_q.push_back(w);
        end
    endtask

    // Window consumer driver.
    initial begin
        forever begin
            @(posedge i_clk); #1;
            case (rmode)
                0: i_win_ready = 1'b1;
                1: i_win_ready = 1'b0;
                2: i_win_ready = ~i_win_ready;
                default: ;
            endcase
        end
    end

    // Monitor / scoreboard.
    always @(negedge i_clk) begin
        if (i_rst) begin
            exp_q.delete();
            win_cnt = 0; rd_cyc = 0; rd_total = 0; rd_model = 0;
            irq_cnt = 0; valid_cyc = 0; prev_stall = 1'b0;
        end else begin
            if (o_win_valid) valid_cyc++;
            if (o_line_irq) irq_cnt++;
            if (prev_stall) chk("stall_hold", {o_win_valid, o_win_data}, {1'b1, prev_data});
            if (o_win_valid && i_win_ready) begin
                chk("win_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("win_data", o_win_data, exp_q.pop_front());
                win_cnt++;
            end
            if (o_win_valid || o_lb_rd != 6'd0)
                chk("lb_rd", o_lb_rd, (o_win_valid && !i_win_ready) ? 6'd0 : mask5(rd_model));
            if (o_lb_rd != 6'd0) begin
                rd_total++;
                rd_cyc++;
                if (rd_cyc == int'(LINE_W)) begin
                    rd_cyc = 0;
                    rd_model = (rd_model + 1) % 6;
                end
            end
            if (i_pix_valid && !o_pix_ready) chk("wr_blocked", o_lb_wr_vld, 6'd0);
            prev_stall = o_win_valid && !i_win_ready;
            prev_data  = o_win_data;
        end
    end

    task automatic do_reset();
        i_rst = 1'b1;
        i_pix_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        cur_line = 0;
        cur_col = 0;
    endtask

    task automatic send(input int n);
        int acc, cyc;
        logic rdy;
        acc = 0; cyc = 0;
        while (acc < n && cyc < n * 4 + 4000) begin
            i_pix_valid = 1'b1;
            i_pix_data  = pix(cur_line, cur_col);
            @(negedge i_clk); rdy = o_pix_ready;
            @(posedge i_clk); #1;
            cyc++;
            if (rdy) begin
                acc++;
                cur_col++;
                if (cur_col == int'(LINE_W)) begin
                    cur_col = 0;
                    cur_line++;
                    if (cur_line >= 5) push_line(cur_line - 5);
                end
            end
        end
        i_pix_valid = 1'b0;
        chk("send_done", acc, n);
    endtask

    task automatic wait_wins(input int target, input int budget, input string nm);
        int c;
        c = 0;
        while (win_cnt < target && c < budget) begin
            @(negedge i_clk);
            c++;
        end
        repeat (6) @(negedge i_clk);
        chk(nm, win_cnt, target);
        chk({nm, "_q_empty"}, exp_q.size(), 0);
    endtask

    function automatic int irq_exp(input int n);
`ifdef LBC_IRQ_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    typedef struct {
        logic       pv;
        logic       wr;
        logic       e_rdy;
        logic [5:0] e_wv;
        logic [5:0] e_rd;
        logic       e_val;
        logic       e_irq;
    } vec_t;

    vec_t vecs[5];
    logic got;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 6'd1, 6'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 6'd1, 6'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0};

        // Reset state and idle write strobes.
        rmode = 3;
        do_reset();
        foreach (vecs[i]) begin
            i_pix_valid = vecs[i].pv;
            i_win_ready = vecs[i].wr;
            @(negedge i_clk);
            chk("vec_ready", o_pix_ready, vecs[i].e_rdy);
            chk("vec_wr_vld", o_lb_wr_vld, vecs[i].e_wv);
            chk("vec_lb_rd", o_lb_rd, vecs[i].e_rd);
            chk("vec_win_valid", o_win_valid, vecs[i].e_val);
            chk("vec_irq", o_line_irq, vecs[i].e_irq);
            @(posedge i_clk); #1;
        end
        i_pix_valid = 1'b0;

        // Five lines, consumer always ready.
        rmode = 0; lmul = 3;
        do_reset();
        send(5 * LINE_W);
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            @(negedge i_clk);
            if (o_win_valid) got = 1'b1;
        end
        chk("valid_rise", got, 1);
        wait_wins(NWIN, 1500, "t1_wins");
        chk("t1_rd_cycles", rd_total, LINE_W);
        chk("t1_irq", irq_cnt, irq_exp(1));

        // Ramp: all lines equal to the column index.
        lmul = 0;
        do_reset();
        send(5 * LINE_W);
        wait_wins(NWIN, 1500, "t2_wins");
        chk("t2_rd_cycles", rd_total, LINE_W);

        // Fill all six buffers without reading, then release one line.
        rmode = 1; lmul = 1;
        do_reset();
        send(6 * LINE_W);
        @(negedge i_clk);
        chk("t3_full", o_pix_ready, 0);
        @(posedge i_clk); #1;
        for (int i = 0; i < 10; i++) begin
            i_pix_valid = 1'b1;
            @(negedge i_clk);
            chk("t3_no_write", o_lb_wr_vld, 6'd0);
            @(posedge i_clk); #1;
        end
        i_pix_valid = 1'b0;
        rmode = 0;
        got = 1'b0;
        for (int i = 0; i < 700 && !got; i++) begin
            @(negedge i_clk);
            if (o_pix_ready) got = 1'b1;
        end
        chk("t3_ready_back", got, 1);
        chk("t3_one_release", rd_total, LINE_W);
        wait_wins(2 * NWIN, 2000, "t3_wins");

        // Consumer toggling ready every cycle.
        rmode = 2; lmul = 5;
        do_reset();
        send(5 * LINE_W);
        wait_wins(NWIN, 3000, "t4_wins");

        // Twelve lines: both pointers wrap.
        rmode = 0; lmul = 11;
        do_reset();
        send(12 * LINE_W);
        wait_wins(8 * NWIN, 3000, "t5_wins");
        chk("t5_rd_cycles", rd_total, 8 * LINE_W);
        chk("t5_irq", irq_cnt, irq_exp(8));

        // Reset in the middle of a read line.
        rmode = 0; lmul = 2;
        do_reset();
        send(5 * LINE_W);
        for (int i = 0; i < 1000 && win_cnt < 100; i++) @(negedge i_clk);
        chk("t6_reached", win_cnt >= 100, 1);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        cur_line = 0; cur_col = 0;
        @(negedge i_clk);
        chk("t6_valid", o_win_valid, 0);
        chk("t6_ready", o_pix_ready, 1);
        chk("t6_lb_rd", o_lb_rd, 6'd0);
        @(posedge i_clk); #1;
        lmul = 7;
        send(4 * LINE_W);
        repeat (20) @(negedge i_clk);
        chk("t6_idle", valid_cyc, 0);
        @(posedge i_clk); #1;
        send(LINE_W);
        wait_wins(NWIN, 1500, "t6_wins");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
